pc_reg: RTL and testbench

PC_REG -- requirements
Module: pc_reg

---
 rtl/pc_reg.sv | 139 +++++++++++++
 tb/tb_pc_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_reg.sv
// LC-3b program counter register with next-PC mux, alignment fault capture and wrap pulse.
// Optional PC history trace enabled by defining PC_REG_TRACE_EN.
module pc_reg #(
    parameter logic [15:0] RESET_VEC = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_pc,
    input  logic [1:0]  pcmux,
    input  logic [15:0] bus_in,
    input  logic [15:0] adder_in,
    input  logic        clr_fault,
`ifdef PC_REG_TRACE_EN
    input  logic [1:0]  trace_sel,
    output logic [15:0] trace_pc,
`endif
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        misalign,
    output logic [15:0] fault_addr,
    output logic        wrapped
);

    localparam logic [1:0] SEL_PLUS2 = 2'b00;
    localparam logic [1:0] SEL_BUS   = 2'b01;
    localparam logic [1:0] SEL_ADDER = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    localparam logic [15:0] RESET_PC = {RESET_VEC[15:1], 1'b0};

    logic [15:0] pc_q,         pc_d;
    logic        misalign_q,   misalign_d;
    logic [15:0] fault_addr_q, fault_addr_d;
    logic        wrapped_q,    wrapped_d;

    logic [15:0] raw_target;
    logic        target_load;
    logic        fault_now;

    assign pc_plus2 = pc_q + 16'd2;

    always_comb begin
        raw_target  = pc_plus2;
        target_load = 1'b0;
        case (pcmux)
            SEL_PLUS2: raw_target = pc_plus2;
            SEL_BUS: begin
                raw_target  = bus_in;
                target_load = 1'b1;
            end
            SEL_ADDER: begin
                raw_target  = adder_in;
                target_load = 1'b1;
            end
            SEL_HOLD:  raw_target = pc_q;
            default:   raw_target = pc_q;
        endcase
    end

    // Only external targets can be odd; PC+2 from an even PC never faults.
    assign fault_now = ld_pc && target_load && raw_target[0];

    always_comb begin
        pc_d = pc_q;
        if (ld_pc && (pcmux != SEL_HOLD)) begin
            pc_d = {raw_target[15:1], 1'b0};
        end
    end

    always_comb begin
        misalign_d   = misalign_q;
        fault_addr_d = fault_addr_q;
        if (fault_now) begin
            misalign_d   = 1'b1;
            fault_addr_d = raw_target;
        end else if (clr_fault) begin
            misalign_d   = 1'b0;
        end
    end

    always_comb begin
        wrapped_d = ld_pc && (pcmux == SEL_PLUS2) && (pc_q == 16'hFFFE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            misalign_q   <= 1'b0;
            fault_addr_q <= 16'h0000;
            wrapped_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misalign_q   <= misalign_d;
            fault_addr_q <= fault_addr_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign pc_out     = pc_q;
    assign misalign   = misalign_q;
    assign fault_addr = fault_addr_q;
    assign wrapped    = wrapped_q;

`ifdef PC_REG_TRACE_EN
    // Entry 0 holds the PC value that was current just before the newest load.
    logic [15:0] hist_q [4];
    logic [15:0] hist_d [4];
    logic        hist_push;

    assign hist_push = ld_pc && (pcmux != SEL_HOLD);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (hist_push) begin
            hist_d[0] = pc_q;
            for (int i = 1; i < 4; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign trace_pc = hist_q[trace_sel];
`endif

endmodule

// File: tb/tb_pc_reg.sv
// Directed table-driven bench for pc_reg plus hand-written wrap and trace sequences.
module tb_pc_reg;

    logic        clk;
    logic        reset;
    logic        ld_pc;
    logic [1:0]  pcmux;
    logic [15:0] bus_in;
    logic [15:0] adder_in;
    logic        clr_fault;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        misalign;
    logic [15:0] fault_addr;
    logic        wrapped;
`ifdef PC_REG_TRACE_EN
    logic [1:0]  trace_sel;
    logic [15:0] trace_pc;
`endif

    int n_vec;
    int n_bad;

    pc_reg #(.RESET_VEC(16'h0200)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_pc      (ld_pc),
        .pcmux      (pcmux),
        .bus_in     (bus_in),
        .adder_in   (adder_in),
        .clr_fault  (clr_fault),
`ifdef PC_REG_TRACE_EN
        .trace_sel  (trace_sel),
        .trace_pc   (trace_pc),
`endif
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .misalign   (misalign),
        .fault_addr (fault_addr),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [1:0]  mux;
        logic [15:0] bus;
        logic [15:0] add;
        logic        clr;
        logic [15:0] e_pc;
        logic [15:0] e_p2;
        logic        e_mis;
        logic [15:0] e_fa;
        logic        e_wr;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic rst, input logic ld, input logic [1:0] mux,
                                input logic [15:0] bus, input logic [15:0] add, input logic clr,
                                input logic [15:0] e_pc, input logic [15:0] e_p2,
                                input logic e_mis, input logic [15:0] e_fa, input logic e_wr);
        vec_t v;
        v.rst = rst; v.ld = ld; v.mux = mux; v.bus = bus; v.add = add; v.clr = clr;
        v.e_pc = e_pc; v.e_p2 = e_p2; v.e_mis = e_mis; v.e_fa = e_fa; v.e_wr = e_wr;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic ld, input logic [1:0] mux,
                         input logic [15:0] bus, input logic [15:0] add, input logic clr);
        @(negedge clk);
        reset = rst; ld_pc = ld; pcmux = mux; bus_in = bus; adder_in = add; clr_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] e_pc, input logic [15:0] e_p2,
                         input logic e_mis, input logic [15:0] e_fa, input logic e_wr);
        n_vec++;
        if (pc_out !== e_pc) begin
            n_bad++;
            $display("FAIL %s pc_out got %h want %h", name, pc_out, e_pc);
        end
        if (pc_plus2 !== e_p2) begin
            n_bad++;
            $display("FAIL %s pc_plus2 got %h want %h", name, pc_plus2, e_p2);
        end
        if (misalign !== e_mis) begin
            n_bad++;
            $display("FAIL %s misalign got %b want %b", name, misalign, e_mis);
        end
        if (fault_addr !== e_fa) begin
            n_bad++;
            $display("FAIL %s fault_addr got %h want %h", name, fault_addr, e_fa);
        end
        if (wrapped !== e_wr) begin
            n_bad++;
            $display("FAIL %s wrapped got %b want %b", name, wrapped, e_wr);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0; ld_pc = 1'b0; pcmux = 2'b11;
        bus_in = 16'h0000; adder_in = 16'h0000; clr_fault = 1'b0;
`ifdef PC_REG_TRACE_EN
        trace_sel = 2'd0;
`endif

        //              rst   ld    mux    bus       adder     clr   pc        pc+2      mis   fa        wr
        vecs[0]  = mk(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0200, 16'h0202, 1'b0, 16'h0000, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0202, 16'h0204, 1'b0, 16'h0000, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0204, 16'h0206, 1'b0, 16'h0000, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0206, 16'h0208, 1'b0, 16'h0000, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 2'b01, 16'h3000, 16'h0000, 1'b0, 16'h0206, 16'h0208, 1'b0, 16'h0000, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 2'b01, 16'h3000, 16'h0000, 1'b0, 16'h3000, 16'h3002, 1'b0, 16'h0000, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 2'b10, 16'h0000, 16'h4001, 1'b0, 16'h4000, 16'h4002, 1'b1, 16'h4001, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 2'b11, 16'h5555, 16'h7777, 1'b0, 16'h4000, 16'h4002, 1'b1, 16'h4001, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 2'b01, 16'h1235, 16'h0000, 1'b1, 16'h1234, 16'h1236, 1'b1, 16'h1235, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 2'b01, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h1236, 1'b0, 16'h1235, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 2'b01, 16'hFFFE, 16'h0000, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 16'h1235, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b0, 16'h1235, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b0, 16'h1235, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 2'b10, 16'h0000, 16'h0007, 1'b0, 16'h0006, 16'h0008, 1'b1, 16'h0007, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 2'b01, 16'h0009, 16'h0000, 1'b0, 16'h0008, 16'h000A, 1'b1, 16'h0009, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 2'b10, 16'h0000, 16'h0011, 1'b0, 16'h0008, 16'h000A, 1'b1, 16'h0009, 1'b0);
        vecs[16] = mk(1'b1, 1'b1, 2'b01, 16'h5555, 16'h0000, 1'b1, 16'h0200, 16'h0202, 1'b0, 16'h0000, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 2'b10, 16'h0000, 16'hFFFE, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vecs[18] = mk(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0200, 16'h0202, 1'b0, 16'h0000, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0200, 16'h0202, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].mux, vecs[i].bus, vecs[i].add, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_p2, vecs[i].e_mis,
                  vecs[i].e_fa, vecs[i].e_wr);
        end

        // Wrap followed by continued sequential fetch: pulse must last exactly one cycle.
        drive(1'b0, 1'b1, 2'b01, 16'hFFFE, 16'h0000, 1'b0);
        check("wrap_setup", 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0);
        check("wrap_pulse", 16'h0000, 16'h0002, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0);
        check("wrap_after", 16'h0002, 16'h0004, 1'b0, 16'h0000, 1'b0);

        // Hold with mux=11 at FFFE must not wrap.
        drive(1'b0, 1'b1, 2'b10, 16'h0000, 16'hFFFF, 1'b0);
        check("odd_fffe", 16'hFFFE, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 16'h0000, 16'h0000, 1'b0);
        check("hold_fffe", 16'hFFFE, 16'h0000, 1'b1, 16'hFFFF, 1'b0);

        // Wrap edge and reset coincide: reset wins, no pulse.
        drive(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0);
        check("wrap_reset", 16'h0200, 16'h0202, 1'b0, 16'h0000, 1'b0);

`ifdef PC_REG_TRACE_EN
        drive(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, 1'b1, 2'b01, 16'h3000, 16'h0000, 1'b0);
        check("trace_load", 16'h3000, 16'h3002, 1'b0, 16'h0000, 1'b0);
        trace_sel = 2'd0;
        #1;
        n_vec++;
        if (trace_pc !== 16'h0202) begin
            n_bad++;
            $display("FAIL trace_sel0 got %h want %h", trace_pc, 16'h0202);
        end
        trace_sel = 2'd1;
        #1;
        n_vec++;
        if (trace_pc !== 16'h0200) begin
            n_bad++;
            $display("FAIL trace_sel1 got %h want %h", trace_pc, 16'h0200);
        end
        drive(1'b1, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0);
        for (int s = 0; s < 4; s++) begin
            trace_sel = s[1:0];
            #1;
            n_vec++;
            if (trace_pc !== 16'h0000) begin
                n_bad++;
                $display("FAIL trace_reset%0d got %h want %h", s, trace_pc, 16'h0000);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
